// File: rtl/mips_dump_if.sv
// Dump stream port of the MIPS state dump engine: tagged beats under a valid/ready handshake.
interface mips_dump_if #(
  parameter int DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_tag;
  logic [15:0]       out_index;
  logic [DATA_W-1:0] out_data;

  modport master (output out_valid, output out_tag, output out_index, output out_data,
                  input  out_ready);
  modport slave  (input  out_valid, input  out_tag, input  out_index, input  out_data,
                  output out_ready);
endinterface

// File: rtl/mips_state_dump_engine.sv
// End-of-run dump unit: detects halt/timeout/request, freezes the core and streams PC, registers, memory.
// Optional trailing checksum beat is built when MIPS_DUMP_CHECKSUM_EN is defined.
module mips_state_dump_engine #(
  parameter int                 NUM_REGS    = 32,
  parameter int                 DATA_W      = 32,
  parameter logic [DATA_W-1:0]  DM_BASE     = '0,
  parameter int                 DM_WORDS    = 12,
  parameter int                 HALT_CYCLES = 4,
  parameter int                 CYCLE_LIMIT = 1000,
  localparam int                RA_W        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc,
  input  logic              dump_req,
  output logic              cpu_stall,
  output logic [RA_W-1:0]   rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [DATA_W-1:0] dm_raddr,
  input  logic [DATA_W-1:0] dm_rdata,
  mips_dump_if.master       dump,
  output logic              done
);

`ifdef MIPS_DUMP_CHECKSUM_EN
  localparam int LAST_ITEM = NUM_REGS + DM_WORDS + 1;
`else
  localparam int LAST_ITEM = NUM_REGS + DM_WORDS;
`endif

  typedef enum logic [1:0] {ST_RUN, ST_FETCH, ST_SEND, ST_DONE} state_t;

  state_t            state_r;
  logic [31:0]       cyc_cnt_r;
  logic [31:0]       stable_cnt_r;
  logic [DATA_W-1:0] prev_pc_r;
  logic [DATA_W-1:0] snap_pc_r;
  logic [15:0]       item_r;
`ifdef MIPS_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum_r;
`endif

  logic              trig_s;
  logic [15:0]       nxt_item_s;
  logic [RA_W-1:0]   nxt_rf_addr_s;
  logic [DATA_W-1:0] nxt_dm_addr_s;

  // Item numbering: 0 is PC, 1..NUM_REGS registers, then memory words, then checksum.
  function automatic logic [1:0] kind_of(input logic [15:0] n);
    if (n == 16'd0) begin
      kind_of = 2'd0;
    end else if (n <= 16'(NUM_REGS)) begin
      kind_of = 2'd1;
    end else if (n <= 16'(NUM_REGS + DM_WORDS)) begin
      kind_of = 2'd2;
    end else begin
      kind_of = 2'd3;
    end
  endfunction

  // Completion detection and next-item address precomputation.
  always_comb begin
    trig_s = dump_req;
    if ((pc == prev_pc_r) && (stable_cnt_r == 32'(HALT_CYCLES - 1))) begin
      trig_s = 1'b1;
    end else if ((CYCLE_LIMIT != 0) && (cyc_cnt_r == 32'(CYCLE_LIMIT - 1))) begin
      trig_s = 1'b1;
    end else begin
      trig_s = dump_req;
    end
    nxt_item_s    = item_r + 16'd1;
    nxt_rf_addr_s = RA_W'(item_r);
    nxt_dm_addr_s = DM_BASE + (DATA_W'(nxt_item_s - 16'(NUM_REGS + 1)) << 2);
  end

  // Dump sequencer with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_RUN;
      cpu_stall      <= 1'b0;
      done           <= 1'b0;
      rf_raddr       <= '0;
      dm_raddr       <= DM_BASE;
      dump.out_valid <= 1'b0;
      dump.out_tag   <= 2'd0;
      dump.out_index <= 16'd0;
      dump.out_data  <= '0;
      cyc_cnt_r      <= 32'd0;
      stable_cnt_r   <= 32'd0;
      prev_pc_r      <= '0;
      snap_pc_r      <= '0;
      item_r         <= 16'd0;
`ifdef MIPS_DUMP_CHECKSUM_EN
      sum_r          <= '0;
`endif
    end else begin
      case (state_r)
        ST_RUN: begin
          cyc_cnt_r    <= cyc_cnt_r + 32'd1;
          prev_pc_r    <= pc;
          stable_cnt_r <= (pc == prev_pc_r) ? stable_cnt_r + 32'd1 : 32'd0;
          if (trig_s) begin
            cpu_stall <= 1'b1;
            snap_pc_r <= pc;
            item_r    <= 16'd0;
`ifdef MIPS_DUMP_CHECKSUM_EN
            sum_r     <= '0;
`endif
            state_r   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          case (kind_of(item_r))
            2'd0: begin
              dump.out_tag   <= 2'd0;
              dump.out_index <= 16'd0;
              dump.out_data  <= snap_pc_r;
            end
            2'd1: begin
              dump.out_tag   <= 2'd1;
              dump.out_index <= item_r - 16'd1;
              dump.out_data  <= rf_rdata;
            end
            2'd2: begin
              dump.out_tag   <= 2'd2;
              dump.out_index <= item_r - 16'(NUM_REGS + 1);
              dump.out_data  <= dm_rdata;
            end
            default: begin
              dump.out_tag   <= 2'd3;
              dump.out_index <= 16'd0;
`ifdef MIPS_DUMP_CHECKSUM_EN
              dump.out_data  <= sum_r;
`else
              dump.out_data  <= '0;
`endif
            end
          endcase
          dump.out_valid <= 1'b1;
          state_r        <= ST_SEND;
        end
        ST_SEND: begin
          if (dump.out_valid && dump.out_ready) begin
            dump.out_valid <= 1'b0;
`ifdef MIPS_DUMP_CHECKSUM_EN
            if (dump.out_tag != 2'd3) begin
              sum_r <= sum_r + dump.out_data;
            end
`endif
            if (item_r == 16'(LAST_ITEM)) begin
              done    <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              item_r <= nxt_item_s;
              // Address registers are loaded one cycle ahead so FETCH sees settled read data.
              case (kind_of(nxt_item_s))
                2'd1:    rf_raddr <= nxt_rf_addr_s;
                2'd2:    dm_raddr <= nxt_dm_addr_s;
                default: ;
              endcase
              state_r <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          done           <= 1'b1;
          dump.out_valid <= 1'b0;
          cpu_stall      <= 1'b1;
        end
        default: begin
          state_r <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_state_dump_engine.sv
// Directed self-checking bench for mips_state_dump_engine (default instance plus a wrapping-window instance).
module tb_mips_state_dump_engine;

`ifdef MIPS_DUMP_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif
  localparam int EXP_A = 45 + CHK;
  localparam int EXP_B = 8 + CHK;

  typedef struct packed {
    logic [1:0]  tag;
    logic [15:0] idx;
    logic [31:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = 32'h0;
  logic        dump_req = 1'b0;
  logic        ready_a = 1'b1;
  logic        ones = 1'b0;

  logic        cpu_stall_a, done_a, cpu_stall_b, done_b;
  logic [4:0]  rf_raddr_a;
  logic [1:0]  rf_raddr_b;
  logic [31:0] rf_rdata_a, rf_rdata_b, dm_raddr_a, dm_raddr_b, dm_rdata_a, dm_rdata_b;

  int    n_checks = 0;
  int    n_errors = 0;
  beat_t q_a[$];
  beat_t q_b[$];

  mips_dump_if #(.DATA_W(32)) dif_a ();
  mips_dump_if #(.DATA_W(32)) dif_b ();

  function automatic logic [31:0] reg_val(input logic one, input logic [31:0] i);
    reg_val = one ? 32'h1 : (32'h1000_0000 + i * 32'h0101);
  endfunction

  function automatic logic [31:0] mem_val(input logic one, input logic [31:0] a);
    mem_val = one ? 32'h1 : (a ^ 32'hA5A5_0000);
  endfunction

  assign rf_rdata_a      = reg_val(ones, 32'(rf_raddr_a));
  assign rf_rdata_b      = reg_val(ones, 32'(rf_raddr_b));
  assign dm_rdata_a      = mem_val(ones, dm_raddr_a);
  assign dm_rdata_b      = mem_val(ones, dm_raddr_b);
  assign dif_a.out_ready = ready_a;
  assign dif_b.out_ready = 1'b1;

  mips_state_dump_engine dut_a (
    .clk(clk), .rst(rst), .pc(pc), .dump_req(dump_req), .cpu_stall(cpu_stall_a),
    .rf_raddr(rf_raddr_a), .rf_rdata(rf_rdata_a), .dm_raddr(dm_raddr_a), .dm_rdata(dm_rdata_a),
    .dump(dif_a), .done(done_a)
  );

  mips_state_dump_engine #(.NUM_REGS(4), .DM_BASE(32'hFFFF_FFF8), .DM_WORDS(3)) dut_b (
    .clk(clk), .rst(rst), .pc(pc), .dump_req(dump_req), .cpu_stall(cpu_stall_b),
    .rf_raddr(rf_raddr_b), .rf_rdata(rf_rdata_b), .dm_raddr(dm_raddr_b), .dm_rdata(dm_rdata_b),
    .dump(dif_b), .done(done_b)
  );

  always #5 clk = ~clk;

  // Record every accepted beat, sampled after the bench has driven its negedge inputs.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (dif_a.out_valid && dif_a.out_ready) q_a.push_back('{dif_a.out_tag, dif_a.out_index, dif_a.out_data});
      if (dif_b.out_valid && dif_b.out_ready) q_b.push_back('{dif_b.out_tag, dif_b.out_index, dif_b.out_data});
    end
  end

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_reset_a(input string name);
    check_eq({name, "_stall"}, 64'(cpu_stall_a), 64'h0);
    check_eq({name, "_valid"}, 64'(dif_a.out_valid), 64'h0);
    check_eq({name, "_tag"},   64'(dif_a.out_tag), 64'h0);
    check_eq({name, "_index"}, 64'(dif_a.out_index), 64'h0);
    check_eq({name, "_data"},  64'(dif_a.out_data), 64'h0);
    check_eq({name, "_done"},  64'(done_a), 64'h0);
    check_eq({name, "_rfa"},   64'(rf_raddr_a), 64'h0);
    check_eq({name, "_dma"},   64'(dm_raddr_a), 64'h0);
  endtask

  task automatic wait_done_a(input string name, output int cyc);
    cyc = 0;
    while (!done_a && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({name, "_done_seen"}, 64'(done_a), 64'h1);
  endtask

  task automatic restart_with_req(input logic [31:0] pc_val);
    rst = 1'b1;
    @(negedge clk);
    pc = pc_val;
    q_a.delete();
    q_b.delete();
    rst = 1'b0;
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
  endtask

  initial begin
    int cyc;
    int edges;
    int n3;

    // Reset state
    pc = 32'h1C;
    repeat (2) @(negedge clk);
    check_reset_a("rst");
    check_eq("rst_b_dma", 64'(dm_raddr_b), 64'hFFFF_FFF8);

    // PC self-loop at 0x1C
    q_a.delete();
    rst = 1'b0;
    edges = 0;
    while (!cpu_stall_a && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    check_eq("t1_halt_edges", 64'(edges), 64'd5);
    wait_done_a("t1", cyc);
    check_eq("t1_done_cycles", 64'(cyc), 64'(2 * EXP_A));
    check_eq("t1_beats", 64'(q_a.size()), 64'(EXP_A));
    check_eq("t1_valid_done", 64'(dif_a.out_valid), 64'h0);
    if (q_a.size() >= 45) begin
      check_eq("t1_pc", 64'(q_a[0]), 64'({2'd0, 16'd0, 32'h1C}));
      for (int i = 0; i < 32; i++)
        check_eq("t1_reg", 64'(q_a[1 + i]), 64'({2'd1, 16'(i), 32'h1000_0000 + 32'(i) * 32'h0101}));
      for (int j = 0; j < 12; j++)
        check_eq("t1_mem", 64'(q_a[33 + j]), 64'({2'd2, 16'(j), (32'(j) * 32'd4) ^ 32'hA5A5_0000}));
    end

    // Timeout trigger with a constantly moving PC
    rst = 1'b1;
    @(negedge clk);
    pc = 32'h400;
    q_a.delete();
    rst = 1'b0;
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
      if (!cpu_stall_a) pc = pc + 32'd4;
    end while (!cpu_stall_a && edges < 1100);
    check_eq("t2_timeout_edges", 64'(edges), 64'd1000);
    repeat (10) @(negedge clk);
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    wait_done_a("t2", cyc);
    repeat (20) @(negedge clk);
    check_eq("t2_beats", 64'(q_a.size()), 64'(EXP_A));
    if (q_a.size() > 0) check_eq("t2_pc", 64'(q_a[0]), 64'({2'd0, 16'd0, 32'h139C}));
    check_eq("t2_done_hold", 64'({done_a, cpu_stall_a, dif_a.out_valid}), 64'b110);

    // Backpressure on REG 5
    restart_with_req(32'h80);
    cyc = 0;
    while (!(dif_a.out_valid && dif_a.out_tag == 2'd1 && dif_a.out_index == 16'd5) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("t3_reg5_seen", 64'(cyc < 200), 64'h1);
    ready_a = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check_eq("t3_hold", 64'({dif_a.out_valid, dif_a.out_tag, dif_a.out_index, dif_a.out_data}),
               64'({1'b1, 2'd1, 16'd5, 32'h1000_0505}));
    end
    ready_a = 1'b1;
    wait_done_a("t3", cyc);
    check_eq("t3_beats", 64'(q_a.size()), 64'(EXP_A));
    if (q_a.size() > 7) begin
      check_eq("t3_reg5", 64'(q_a[6]), 64'({2'd1, 16'd5, 32'h1000_0505}));
      check_eq("t3_reg6", 64'(q_a[7]), 64'({2'd1, 16'd6, 32'h1000_0606}));
    end

    // Reset during MEM 3, then restart by request
    restart_with_req(32'h2000);
    check_eq("t4_req_stall", 64'(cpu_stall_a), 64'h1);
    cyc = 0;
    while (!(dif_a.out_valid && dif_a.out_tag == 2'd2 && dif_a.out_index == 16'd3) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("t4_mem3_seen", 64'(cyc < 200), 64'h1);
    rst = 1'b1;
    #1;
    check_reset_a("t4_abort");
    @(negedge clk);
    rst = 1'b0;
    q_a.delete();
    q_b.delete();
    repeat (2) @(negedge clk);
    check_eq("t4_no_restart", 64'(cpu_stall_a), 64'h0);
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    wait_done_a("t4", cyc);
    check_eq("t4_beats", 64'(q_a.size()), 64'(EXP_A));
    if (q_a.size() > 0) check_eq("t4_first", 64'(q_a[0]), 64'({2'd0, 16'd0, 32'h2000}));

    // Wrapping memory window on the second instance
    check_eq("t5_done_b", 64'(done_b), 64'h1);
    check_eq("t5_beats_b", 64'(q_b.size()), 64'(EXP_B));
    if (q_b.size() >= 8) begin
      check_eq("t5_mem0", 64'(q_b[5]), 64'({2'd2, 16'd0, 32'h5A5A_FFF8}));
      check_eq("t5_mem1", 64'(q_b[6]), 64'({2'd2, 16'd1, 32'h5A5A_FFFC}));
      check_eq("t5_mem2", 64'(q_b[7]), 64'({2'd2, 16'd2, 32'hA5A5_0000}));
    end

    // Checksum beat presence and value with all-ones contents
    ones = 1'b1;
    restart_with_req(32'h10);
    wait_done_a("t6", cyc);
    n3 = 0;
    foreach (q_a[k]) if (q_a[k].tag == 2'd3) n3++;
    check_eq("t6_tag3_count", 64'(n3), 64'(CHK));
    check_eq("t6_beats", 64'(q_a.size()), 64'(EXP_A));
`ifdef MIPS_DUMP_CHECKSUM_EN
    if (q_a.size() == EXP_A) check_eq("t6_sum_a", 64'(q_a[EXP_A - 1]), 64'({2'd3, 16'd0, 32'h3C}));
    if (q_b.size() == EXP_B) check_eq("t6_sum_b", 64'(q_b[EXP_B - 1]), 64'({2'd3, 16'd0, 32'h17}));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
